// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared state encoding and default width for the divide sequencer
package div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } divState_t;

endpackage

// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - execute-stage divide request and HI/LO delivery bundle
// master: pipeline side (drives startE/signedE/flushE/srcaE/srcbE)
// slave : divider side (drives stall_div/busy/hi_out/lo_out/divvalid)
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             startE;
    logic             signedE;
    logic             flushE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             stall_div;
    logic             busy;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             divvalid;

    modport master (
        output startE, signedE, flushE, srcaE, srcbE,
        input  stall_div, busy, hi_out, lo_out, divvalid
    );

    modport slave (
        input  startE, signedE, flushE, srcaE, srcbE,
        output stall_div, busy, hi_out, lo_out, divvalid
    );
endinterface

// File: rtl/div_datapath.sv
// rtl/div_datapath.sv - restoring radix-2 remainder/quotient shift registers
// clk, rst           : clock, async active-high reset
// load               : capture unsigned operands, clear remainder
// step               : commit one quotient bit
// dividendIn/divisorIn: unsigned operand magnitudes
// remNext/quoNext    : result of the step taken this cycle (combinational)
module div_datapath
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividendIn,
    input  logic [WIDTH-1:0] divisorIn,
    output logic [WIDTH-1:0] remNext,
    output logic [WIDTH-1:0] quoNext
);
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] dvsReg;
    logic [WIDTH:0]   shifted;
    logic             borrow;
    logic [WIDTH-1:0] trial;

    // quoReg starts as the dividend; its MSB feeds the remainder while
    // quotient bits fill in from the bottom.
    assign shifted = {remReg, quoReg[WIDTH-1]};
    assign borrow  = shifted < {1'b0, dvsReg};
    // remainder stays below the divisor, so the true difference fits WIDTH bits
    assign trial   = shifted[WIDTH-1:0] - dvsReg;
    assign remNext = borrow ? shifted[WIDTH-1:0] : trial;
    assign quoNext = {quoReg[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remReg <= '0;
            quoReg <= '0;
            dvsReg <= '0;
        end else if (load) begin
            remReg <= '0;
            quoReg <= dividendIn;
            dvsReg <= divisorIn;
        end else if (step) begin
            remReg <= remNext;
            quoReg <= quoNext;
        end
    end
endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - DIV/DIVU sequencer: FSM, iteration count, sign fix, HI/LO registers
// clk, rst : clock, async active-high reset
// bus      : slave side of div_sequencer_if (E-stage request in, stall and HI/LO result out)
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    div_sequencer_if.slave bus
);
    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    divState_t        state;
    divState_t        stateNext;
    logic [CNT_W-1:0] count;
    logic             signA;
    logic             signB;
    logic             load;
    logic             step;
    logic             finish;
    logic             divZero;
    logic [WIDTH-1:0] dividendAbs;
    logic [WIDTH-1:0] divisorAbs;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] quoFixed;
    logic [WIDTH-1:0] remFixed;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic             validReg;

    // Magnitudes held unsigned, so the most negative value needs no extra bit.
    assign dividendAbs = (bus.signedE && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
    assign divisorAbs  = (bus.signedE && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;

    div_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .dividendIn(dividendAbs),
        .divisorIn (divisorAbs),
        .remNext   (remNext),
        .quoNext   (quoNext)
    );

    // signA/signB are only set for signed divides, so DIVU never gets a fix.
    assign quoFixed = (signA ^ signB) ? -quoNext : quoNext;
    assign remFixed = signA ? -remNext : remNext;

    always_comb begin
        stateNext = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        divZero   = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (bus.startE && !bus.flushE) begin
                    load = 1'b1;
                    if (bus.srcbE == '0) begin
                        divZero   = 1'b1;
                        stateNext = DIV_DONE;
                    end else begin
                        stateNext = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                if (bus.flushE) begin
                    stateNext = DIV_IDLE;
                end else begin
                    step = 1'b1;
                    if (count == LAST_STEP) begin
                        finish    = 1'b1;
                        stateNext = DIV_DONE;
                    end
                end
            end
            DIV_DONE: stateNext = DIV_IDLE;
            default:  stateNext = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DIV_IDLE;
            count    <= '0;
            signA    <= 1'b0;
            signB    <= 1'b0;
            hiReg    <= '0;
            loReg    <= '0;
            validReg <= 1'b0;
        end else begin
            state    <= stateNext;
            validReg <= finish | divZero;
            if (load) begin
                count <= '0;
                signA <= bus.signedE & bus.srcaE[WIDTH-1];
                signB <= bus.signedE & bus.srcbE[WIDTH-1];
            end else if (step) begin
                count <= count + 1'b1;
            end
            // Divide by zero reports the raw dividend and an all-ones quotient.
            if (divZero) begin
                hiReg <= bus.srcaE;
                loReg <= '1;
            end else if (finish) begin
                hiReg <= remFixed;
                loReg <= quoFixed;
            end
        end
    end

    assign bus.stall_div = ((state == DIV_IDLE && bus.startE) || state == DIV_RUN) && !bus.flushE;
    assign bus.busy      = state != DIV_IDLE;
    assign bus.hi_out    = hiReg;
    assign bus.lo_out    = loReg;
    assign bus.divvalid  = validReg;
endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer
module tb_div_sequencer;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [W-1:0] prevLo;
    logic [W-1:0] prevHi;

    div_sequencer_if #(.WIDTH(W)) bus ();

    div_sequencer #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit truncating division (remainder takes dividend sign).
    task automatic refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          output logic [W-1:0] lo, output logic [W-1:0] hi);
        longint qa, qb, q, r;
        if (b == 0) begin
            lo = '1;
            hi = a;
        end else begin
            if (sgn) begin
                qa = longint'($signed(a));
                qb = longint'($signed(b));
            end else begin
                qa = {32'd0, a};
                qb = {32'd0, b};
            end
            q  = qa / qb;
            r  = qa % qb;
            lo = q[W-1:0];
            hi = r[W-1:0];
        end
    endtask

    task automatic runDiv(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        logic [W-1:0] expLo, expHi;
        int validCycle, stallCnt, expLat;
        refDiv(a, b, sgn, expLo, expHi);
        expLat = (b == 0) ? 1 : W + 1;
        @(negedge clk);
        check({tag, ".idle_busy"}, bus.busy, 1'b0);
        check({tag, ".idle_valid"}, bus.divvalid, 1'b0);
        bus.startE  = 1'b1;
        bus.signedE = sgn;
        bus.srcaE   = a;
        bus.srcbE   = b;
        bus.flushE  = 1'b0;
        validCycle  = -1;
        stallCnt    = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (bus.divvalid) begin
                validCycle = c;
                break;
            end
            if (bus.stall_div) stallCnt++;
            @(posedge clk);
            #1 bus.startE = 1'b0;
            @(negedge clk);
        end
        check({tag, ".latency"}, validCycle, expLat);
        check({tag, ".stall_cycles"}, stallCnt, expLat);
        check({tag, ".done_stall"}, bus.stall_div, 1'b0);
        check({tag, ".lo"}, bus.lo_out, expLo);
        check({tag, ".hi"}, bus.hi_out, expHi);
        prevLo = expLo;
        prevHi = expHi;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        int           sawValid;
        total = 0;
        bad   = 0;
        prevLo = '0;
        prevHi = '0;
        rst         = 1'b1;
        bus.startE  = 1'b0;
        bus.signedE = 1'b0;
        bus.flushE  = 1'b0;
        bus.srcaE   = '0;
        bus.srcbE   = '0;
        #2;
        check("reset.lo", bus.lo_out, '0);
        check("reset.hi", bus.hi_out, '0);
        check("reset.valid", bus.divvalid, 1'b0);
        check("reset.busy", bus.busy, 1'b0);
        check("reset.stall", bus.stall_div, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        runDiv("divu_100_7", 32'd100, 32'd7, 1'b0);
        runDiv("div_m7_2", -32'sd7, 32'd2, 1'b1);
        runDiv("div_7_m2", 32'd7, -32'sd2, 1'b1);
        runDiv("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        runDiv("divu_5_0", 32'd5, 32'd0, 1'b0);
        runDiv("div_m9_0", -32'sd9, 32'd0, 1'b1);

        // flush with start in IDLE: nothing starts
        @(negedge clk);
        bus.startE = 1'b1;
        bus.flushE = 1'b1;
        bus.srcaE  = 32'd50;
        bus.srcbE  = 32'd5;
        #1 check("flush_idle.stall", bus.stall_div, 1'b0);
        @(posedge clk);
        #1;
        bus.startE = 1'b0;
        bus.flushE = 1'b0;
        check("flush_idle.busy", bus.busy, 1'b0);

        // flush at RUN cycle 10
        @(negedge clk);
        bus.startE  = 1'b1;
        bus.signedE = 1'b0;
        bus.srcaE   = $urandom;
        bus.srcbE   = 32'd3;
        @(posedge clk);
        #1 bus.startE = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flushE = 1'b1;
        #1;
        check("flush_run.stall", bus.stall_div, 1'b0);
        check("flush_run.busy_before", bus.busy, 1'b1);
        @(posedge clk);
        #1 bus.flushE = 1'b0;
        check("flush_run.busy_after", bus.busy, 1'b0);
        sawValid = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.divvalid) sawValid++;
        end
        check("flush_run.no_valid", sawValid, 0);
        check("flush_run.lo_kept", bus.lo_out, prevLo);
        check("flush_run.hi_kept", bus.hi_out, prevHi);
        runDiv("divu_9_3", 32'd9, 32'd3, 1'b0);

        // randomized divides, issued back to back
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(1, 15));
                1: rb = -32'($urandom_range(1, 15));
                2: rb = 32'($urandom_range(1, 65535));
                default: rb = $urandom;
            endcase
            if (i == 4) rb = '0;
            runDiv($sformatf("rand%0d", i), ra, rb, rs);
        end

        // async reset mid-RUN
        @(negedge clk);
        bus.startE  = 1'b1;
        bus.signedE = 1'b1;
        bus.srcaE   = 32'd1000;
        bus.srcbE   = 32'd7;
        @(posedge clk);
        #1 bus.startE = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst.lo", bus.lo_out, '0);
        check("arst.hi", bus.hi_out, '0);
        check("arst.busy", bus.busy, 1'b0);
        check("arst.stall", bus.stall_div, 1'b0);
        check("arst.valid", bus.divvalid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        runDiv("post_rst", -32'sd100, 32'd7, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
